// File: rtl/parking_occupancy_tracker_pkg.sv
// parking_occupancy_tracker_pkg: shared lot-status encodings and default lot geometry.
package parking_occupancy_tracker_pkg;
  localparam int DEF_CAPACITY    = 100;
  localparam int DEF_NEAR_MARGIN = 5;
  localparam int DEF_HYST        = 2;
  typedef enum logic [1:0] {
    ST_AVAIL = 2'b00,
    ST_NEAR  = 2'b01,
    ST_FULL  = 2'b10
  } status_t;
endpackage

// File: rtl/occupancy_status_fsm.sv
// occupancy_status_fsm: AVAIL/NEAR/FULL lot status with hysteresis, driven by the next occupancy count.
module occupancy_status_fsm
  import parking_occupancy_tracker_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int NEAR_MARGIN = DEF_NEAR_MARGIN,
  parameter int HYST        = DEF_HYST,
  localparam int CW         = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] i_cnt_nxt,
  output status_t       o_status,
  output logic          o_lot_full,
  output logic          o_gate_allow
);
  localparam logic [CW-1:0] CAP      = CW'(CAPACITY);
  localparam logic [CW-1:0] NEAR_TH  = CW'(CAPACITY - NEAR_MARGIN);
  localparam logic [CW-1:0] AVAIL_TH = CW'(CAPACITY - NEAR_MARGIN - HYST);
  localparam logic [CW-1:0] NEAR_HI  = CW'(CAPACITY - HYST);
  status_t w_nxt;
  always_comb begin
    w_nxt = ST_AVAIL;
    case (o_status)
      ST_AVAIL: w_nxt = (i_cnt_nxt == CAP) ? ST_FULL : (i_cnt_nxt >= NEAR_TH) ? ST_NEAR : ST_AVAIL;
      ST_NEAR:  w_nxt = (i_cnt_nxt == CAP) ? ST_FULL : (i_cnt_nxt < AVAIL_TH) ? ST_AVAIL : ST_NEAR;
      ST_FULL:  w_nxt = (i_cnt_nxt < AVAIL_TH) ? ST_AVAIL : (i_cnt_nxt <= NEAR_HI) ? ST_NEAR : ST_FULL;
      default:  w_nxt = ST_AVAIL;
    endcase
  end
  // Sign and barrier outputs decode the next state so they change on the same edge as status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_status     <= ST_AVAIL;
      o_lot_full   <= 1'b0;
      o_gate_allow <= 1'b1;
    end else begin
      o_status     <= w_nxt;
      o_lot_full   <= (w_nxt == ST_FULL);
      o_gate_allow <= (w_nxt != ST_FULL);
    end
  end
endmodule

// File: rtl/parking_occupancy_tracker.sv
// parking_occupancy_tracker: saturating occupancy counter with sticky range errors and lot-status FSM.
module parking_occupancy_tracker
  import parking_occupancy_tracker_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int NEAR_MARGIN = DEF_NEAR_MARGIN,
  parameter int HYST        = DEF_HYST,
  localparam int CW         = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enter,
  input  logic          exit,
  input  logic          clr_err,
  output logic [CW-1:0] count,
  output logic [1:0]    status,
  output logic          lot_full,
  output logic          gate_allow,
  output logic          empty,
  output logic          changed,
  output logic          err_overflow,
  output logic          err_underflow
);
  localparam logic [CW-1:0] CAP = CW'(CAPACITY);
  logic [CW-1:0] r_count, w_cnt_nxt;
  logic w_add, w_sub, w_ovf, w_unf;
  logic r_empty, r_changed, r_ovf, r_unf;
  status_t w_status;
  // Simultaneous enter and exit cancel out, so neither raises an error.
  always_comb begin
    w_add     = enter & ~exit;
    w_sub     = exit & ~enter;
    w_ovf     = w_add & (r_count == CAP);
    w_unf     = w_sub & (r_count == '0);
    w_cnt_nxt = (w_add & ~w_ovf) ? r_count + CW'(1) :
                (w_sub & ~w_unf) ? r_count - CW'(1) : r_count;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_changed <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_count   <= w_cnt_nxt;
      r_empty   <= (w_cnt_nxt == '0);
      r_changed <= (w_cnt_nxt != r_count);
      r_ovf     <= w_ovf | (r_ovf & ~clr_err);
      r_unf     <= w_unf | (r_unf & ~clr_err);
    end
  end
  occupancy_status_fsm #(
    .CAPACITY   (CAPACITY),
    .NEAR_MARGIN(NEAR_MARGIN),
    .HYST       (HYST)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cnt_nxt   (w_cnt_nxt),
    .o_status    (w_status),
    .o_lot_full  (lot_full),
    .o_gate_allow(gate_allow)
  );
  assign status        = w_status;
  assign count         = r_count;
  assign empty         = r_empty;
  assign changed       = r_changed;
  assign err_overflow  = r_ovf;
  assign err_underflow = r_unf;
endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// tb_parking_occupancy_tracker: directed plus random stimulus against a behavioural lot model.
module tb_parking_occupancy_tracker;
  localparam int CAP = 8;
  localparam int NM  = 2;
  localparam int HY  = 2;
  localparam int CW  = $clog2(CAP + 1);
  logic clk = 1'b0, rst_n = 1'b0, enter = 1'b0, exit = 1'b0, clr_err = 1'b0;
  logic [CW-1:0] count;
  logic [1:0] status;
  logic lot_full, gate_allow, empty, changed, err_overflow, err_underflow;
  int checks = 0, failures = 0;
  int m_cnt = 0, m_st = 0, m_changed = 0, m_empty = 1, m_ovf = 0, m_unf = 0;

  parking_occupancy_tracker #(.CAPACITY(CAP), .NEAR_MARGIN(NM), .HYST(HY)) dut (
    .clk(clk), .rst_n(rst_n), .enter(enter), .exit(exit), .clr_err(clr_err),
    .count(count), .status(status), .lot_full(lot_full), .gate_allow(gate_allow),
    .empty(empty), .changed(changed), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ":count"}, int'(count), m_cnt);
    chk({ctx, ":status"}, int'(status), m_st);
    chk({ctx, ":lot_full"}, int'(lot_full), int'(m_st == 2));
    chk({ctx, ":gate_allow"}, int'(gate_allow), int'(m_st != 2));
    chk({ctx, ":empty"}, int'(empty), m_empty);
    chk({ctx, ":changed"}, int'(changed), m_changed);
    chk({ctx, ":err_overflow"}, int'(err_overflow), m_ovf);
    chk({ctx, ":err_underflow"}, int'(err_underflow), m_unf);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_changed = 0; m_empty = 1; m_ovf = 0; m_unf = 0;
  endtask

  // Lot behaviour restated from the occupancy rules: saturate at the ends, flag misuse, hysteresis status.
  task automatic model_step(input bit e, input bit x, input bit c);
    int nxt;
    bit so, su;
    nxt = m_cnt; so = 0; su = 0;
    if (e && !x) begin
      if (m_cnt == CAP) so = 1; else nxt = m_cnt + 1;
    end else if (x && !e) begin
      if (m_cnt == 0) su = 1; else nxt = m_cnt - 1;
    end
    m_ovf = so ? 1 : (c ? 0 : m_ovf);
    m_unf = su ? 1 : (c ? 0 : m_unf);
    m_changed = int'(nxt != m_cnt);
    m_empty = int'(nxt == 0);
    if (m_st == 0) m_st = (nxt == CAP) ? 2 : (nxt >= CAP - NM) ? 1 : 0;
    else if (m_st == 1) m_st = (nxt == CAP) ? 2 : (nxt < CAP - NM - HY) ? 0 : 1;
    else m_st = (nxt < CAP - NM - HY) ? 0 : (nxt <= CAP - HY) ? 1 : 2;
    m_cnt = nxt;
  endtask

  task automatic step(input bit e, input bit x, input bit c, input string ctx);
    @(negedge clk);
    enter = e; exit = x; clr_err = c;
    @(posedge clk);
    model_step(e, x, c);
    #1;
    chk_all(ctx);
    enter = 1'b0; exit = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("reset");
    step(0, 0, 0, "idle");
    repeat (6) step(1, 0, 0, "fill_near");
    chk("near_reached", int'(status), 1);
    repeat (2) step(1, 0, 0, "fill_full");
    chk("full_reached", int'(status), 2);
    step(0, 1, 0, "full_hyst");
    chk("full_held_at7", int'(status), 2);
    step(0, 1, 0, "full_to_near");
    repeat (3) step(0, 1, 0, "near_to_avail");
    chk("avail_at3", int'(status), 0);
    repeat (5) step(1, 0, 0, "refill");
    step(1, 0, 0, "overflow");
    chk("ovf_set", int'(err_overflow), 1);
    step(1, 0, 1, "ovf_set_beats_clr");
    step(0, 0, 1, "ovf_clr");
    chk("ovf_cleared", int'(err_overflow), 0);
    step(1, 1, 0, "both_at_cap");
    repeat (8) step(0, 1, 0, "drain");
    step(0, 1, 0, "underflow");
    chk("unf_set", int'(err_underflow), 1);
    step(1, 1, 0, "both_at_zero");
    step(0, 0, 1, "unf_clr");
    repeat (5) step(1, 0, 0, "to_five");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    enter = 1'b1;
    @(posedge clk);
    #1;
    chk_all("pulse_in_reset");
    enter = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, "post_reset");
    for (int i = 0; i < 400; i++) begin
      int r;
      bit e, x;
      r = int'($urandom_range(0, 9));
      e = (r < 4) || (r == 8);
      x = (r >= 4 && r < 8) || (r == 8);
      step(e, x, $urandom_range(0, 15) == 0, "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
